bcd_counter_4digit: RTL

//  Four-digit BCD up/down counter; direct consumer of the divided clock level (clk_div, ~2 Hz from 50 MHz).
//  i_tick is sampled on i_clk; each rising edge of it advances the count by one.

---
 rtl/bcd_counter_4digit_pkg.sv | 13 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_counter_4digit.sv | 79 +++++++
 3 files changed

// File: rtl/bcd_counter_4digit_pkg.sv
// Shared constants for the display chain: BCD digit geometry, default digit
// count, and the clock/divider rates that the divider and display driver also use.
package bcd_counter_4digit_pkg;

  localparam int              BCD_W          = 4;
  localparam logic [BCD_W-1:0] BCD_MAX       = 4'd9;
  localparam int              DEF_NUM_DIGITS = 4;

  localparam int CLK_HZ   = 50_000_000;
  localparam int TICK_HZ  = 2;
  localparam int DIV_HALF = CLK_HZ / (2 * TICK_HZ);

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the chained counter: counts up or down when enabled and
// flags when the next enabled step will roll it over.
module bcd_digit
  import bcd_counter_4digit_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_up,
  output logic [BCD_W-1:0] o_q,
  output logic             o_roll
);

  // NOTE: state registers use non-blocking assignments so every digit
  // samples the pre-edge values of its neighbours' roll flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      if (i_up) begin
        // An out-of-range nibble collapses to 0 instead of continuing past 9.
        o_q <= (o_q >= BCD_MAX) ? '0 : o_q + BCD_W'(1);
      end else begin
        o_q <= (o_q == '0)     ? BCD_MAX :
               (o_q > BCD_MAX) ? '0      : o_q - BCD_W'(1);
      end
    end
  end

  assign o_roll = i_up ? (o_q == BCD_MAX) : (o_q == '0);

endmodule

// File: rtl/bcd_counter_4digit.sv
// Multi-digit BCD up/down counter advanced by rising edges of a divided-clock
// level sampled on i_clk; optional wrap with carry/borrow pulses, else saturate.
module bcd_counter_4digit
  import bcd_counter_4digit_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int WRAP       = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_tick,
  input  logic                        i_run,
  input  logic                        i_clear,
  input  logic                        i_up,
  output logic [BCD_W*NUM_DIGITS-1:0] o_bcd,
  output logic                        o_carry,
  output logic                        o_borrow,
  output logic                        o_at_limit
);

  logic                  tick_d;
  logic                  step;
  logic                  at_end;
  logic                  advance;
  logic                  wrap_on;
  logic [NUM_DIGITS-1:0] roll;
  logic [NUM_DIGITS-1:0] en;

  assign wrap_on = (WRAP != 0);

  // NOTE: tick_d resets high so a tick already high when reset releases is
  // not mistaken for a fresh rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tick_d <= 1'b1;
    else          tick_d <= i_tick;
  end

  assign step    = i_tick & ~tick_d & i_run;
  assign at_end  = &roll;
  assign advance = step & ~(at_end & ~wrap_on);

  assign en[0] = advance;

  genvar k;
  generate
    for (k = 1; k < NUM_DIGITS; k++) begin : g_en
      assign en[k] = en[k-1] & roll[k-1];
    end

    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (i_clear),
        .i_en   (en[k]),
        .i_up   (i_up),
        .o_q    (o_bcd[k*BCD_W +: BCD_W]),
        .o_roll (roll[k])
      );
    end
  endgenerate

  // Pulses last exactly one cycle because they are recomputed every edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_carry  <= 1'b0;
      o_borrow <= 1'b0;
    end else if (i_clear) begin
      o_carry  <= 1'b0;
      o_borrow <= 1'b0;
    end else begin
      o_carry  <= step &  i_up & at_end & wrap_on;
      o_borrow <= step & ~i_up & at_end & wrap_on;
    end
  end

  assign o_at_limit = at_end;

endmodule
